// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage control path: opcodes, ALU op codes,
// destination / write-back / branch-type selects and the control bundle.
package ctrl_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLT   = 6'd6;
    localparam logic [5:0] OP_BLE   = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LI    = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // ALU op codes
    localparam logic [2:0] ALU_FUNCT = 3'b000;  // R-type, funct field decides
    localparam logic [2:0] ALU_SUB   = 3'b001;  // BEQ / BLT / BLE compare
    localparam logic [2:0] ALU_NE    = 3'b010;  // BNE compare
    localparam logic [2:0] ALU_ADD   = 3'b011;  // ADDI and address generation
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_LI    = 3'b110;
    localparam logic [2:0] ALU_JUMP  = 3'b111;

    // Destination register select
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // Write-back source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;
    localparam logic [1:0] WB_PC  = 2'b11;

    // Branch type
    localparam logic [1:0] BT_EQ = 2'b00;
    localparam logic [1:0] BT_LE = 2'b01;
    localparam logic [1:0] BT_LT = 2'b10;
    localparam logic [1:0] BT_NE = 2'b11;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [2:0] aluOp;
        logic       aluSrc;
        logic       regWrite;
        logic [1:0] regDst;
        logic [1:0] memToReg;
        logic       branch;
        logic [1:0] branchType;
        logic       jump;
        logic       memRead;
        logic       memWrite;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/main_ctrl_dec.sv
// Purely combinational main decoder: opcode to control bundle, with a flag
// for opcodes outside the supported set (those decode to the bubble bundle).
module main_ctrl_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal
);

    // Opcode lookup table; unknown opcodes fall through to the bubble bundle
    always_comb begin
        ctrl    = CTRL_BUBBLE;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.aluOp    = ALU_FUNCT;
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = RD_RD;
            end
            OP_J: begin
                ctrl.aluOp = ALU_JUMP;
                ctrl.jump  = 1'b1;
            end
            OP_JAL: begin
                ctrl.aluOp    = ALU_JUMP;
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = RD_RA;
                ctrl.memToReg = WB_PC;
                ctrl.jump     = 1'b1;
            end
            OP_BEQ: begin
                ctrl.aluOp      = ALU_SUB;
                ctrl.branch     = 1'b1;
                ctrl.branchType = BT_EQ;
            end
            OP_BNE: begin
                ctrl.aluOp      = ALU_NE;
                ctrl.branch     = 1'b1;
                ctrl.branchType = BT_NE;
            end
            OP_BLT: begin
                ctrl.aluOp      = ALU_SUB;
                ctrl.branch     = 1'b1;
                ctrl.branchType = BT_LT;
            end
            OP_BLE: begin
                ctrl.aluOp      = ALU_SUB;
                ctrl.branch     = 1'b1;
                ctrl.branchType = BT_LE;
            end
            OP_ADDI: begin
                ctrl.aluOp    = ALU_ADD;
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
            end
            OP_ORI: begin
                ctrl.aluOp    = ALU_OR;
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
            end
            OP_LI: begin
                ctrl.aluOp    = ALU_LI;
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = WB_IMM;
            end
            OP_LW: begin
                ctrl.aluOp    = ALU_ADD;
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = WB_MEM;
                ctrl.memRead  = 1'b1;
            end
            OP_SW: begin
                ctrl.aluOp    = ALU_ADD;
                ctrl.aluSrc   = 1'b1;
                ctrl.regDst   = RD_RD;
                ctrl.memWrite = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered ID control stage: decodes the IF/ID instruction into the EX
// control bundle, stalls on a load-use hazard against the load it issued
// last cycle, squashes on flush and counts inserted bubbles.
module id_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int LOAD_STALLS = 1,
    parameter int ALUOP_W     = 3,
    parameter int PERF_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [31:0]        instr_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic               valid_o,
    output logic               branch_o,
    output logic               jump_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               alu_src_o,
    output logic               reg_write_o,
    output logic [1:0]         branch_type_o,
    output logic [1:0]         mem_to_reg_o,
    output logic [1:0]         reg_dst_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic [4:0]         rs_o,
    output logic [4:0]         rt_o,
    output logic [4:0]         wr_addr_o,
    output logic               illegal_o,
    output logic [PERF_W-1:0]  bubbles_o
);

    typedef enum logic {ST_RUN, ST_HOLD} state_t;

    // Remaining HOLD cycles after the hazard cycle itself
    localparam logic [1:0] HOLD_CNT = 2'(LOAD_STALLS - 1);

    // Destination address after reg_dst resolution; 0 when nothing is written
    function automatic logic [4:0] resolveWrAddr(input logic [1:0] regDst,
                                                 input logic       regWrite,
                                                 input logic [4:0] rt,
                                                 input logic [4:0] rd);
        logic [4:0] addr;
        case (regDst)
            RD_RT:   addr = rt;
            RD_RD:   addr = rd;
            RD_RA:   addr = REG_RA;
            default: addr = 5'd0;
        endcase
        return regWrite ? addr : 5'd0;
    endfunction

    // Increment that sticks at all-ones
    function automatic logic [PERF_W-1:0] satInc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

    state_t             state;
    logic [1:0]         cnt;

    ctrl_t              decCtrl;
    logic               decIllegal;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic               unusedInstr;

    logic               hazard;
    logic               stallReq;
    logic               issue;
    logic               insertBubble;
    logic               illegalNext;

    ctrl_t              ctrl_p1;
    logic               vld_p1;
    logic [4:0]         rs_p1;
    logic [4:0]         rt_p1;
    logic [4:0]         wrAddr_p1;
    logic               illegal_p1;
    logic [PERF_W-1:0]  bubbleCnt;

    assign rs          = instr_i[25:21];
    assign rt          = instr_i[20:16];
    assign rd          = instr_i[15:11];
    assign unusedInstr = ^instr_i[10:0];

    main_ctrl_dec uDec (
        .opcode  (instr_i[31:26]),
        .ctrl    (decCtrl),
        .illegal (decIllegal)
    );

    // Hazard compare against the bundle currently in EX, plus issue decisions
    always_comb begin
        hazard = valid_i && vld_p1 && ctrl_p1.memRead && (wrAddr_p1 != 5'd0)
                 && ((wrAddr_p1 == rs) || (wrAddr_p1 == rt));
        stallReq     = (state == ST_HOLD) || ((state == ST_RUN) && hazard);
        stall_o      = !flush_i && stallReq;
        issue        = valid_i && !flush_i && !stallReq && !decIllegal;
        insertBubble = valid_i && (flush_i || stallReq || decIllegal);
        illegalNext  = valid_i && !flush_i && !stallReq && decIllegal;
    end

    // Stall FSM: hazard cycle in RUN, then LOAD_STALLS-1 cycles in HOLD
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state <= ST_RUN;
            cnt   <= 2'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hazard && (HOLD_CNT != 2'd0)) begin
                        state <= ST_HOLD;
                        cnt   <= HOLD_CNT;
                    end
                end
                ST_HOLD: begin
                    cnt <= cnt - 2'd1;
                    if (cnt <= 2'd1) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    // ---- ID -> EX boundary: launch decoded bundle or a bubble ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_p1    <= CTRL_BUBBLE;
            vld_p1     <= 1'b0;
            rs_p1      <= 5'd0;
            rt_p1      <= 5'd0;
            wrAddr_p1  <= 5'd0;
            illegal_p1 <= 1'b0;
        end else begin
            illegal_p1 <= illegalNext;
            if (issue) begin
                ctrl_p1   <= decCtrl;
                vld_p1    <= 1'b1;
                rs_p1     <= rs;
                rt_p1     <= rt;
                wrAddr_p1 <= resolveWrAddr(decCtrl.regDst, decCtrl.regWrite, rt, rd);
            end else begin
                ctrl_p1   <= CTRL_BUBBLE;
                vld_p1    <= 1'b0;
                rs_p1     <= 5'd0;
                rt_p1     <= 5'd0;
                wrAddr_p1 <= 5'd0;
            end
        end
    end

    // Saturating count of bubbles that displaced a real instruction
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubbleCnt <= '0;
        end else if (insertBubble) begin
            bubbleCnt <= satInc(bubbleCnt);
        end
    end

    assign valid_o       = vld_p1;
    assign branch_o      = ctrl_p1.branch;
    assign jump_o        = ctrl_p1.jump;
    assign mem_read_o    = ctrl_p1.memRead;
    assign mem_write_o   = ctrl_p1.memWrite;
    assign alu_src_o     = ctrl_p1.aluSrc;
    assign reg_write_o   = ctrl_p1.regWrite;
    assign branch_type_o = ctrl_p1.branchType;
    assign mem_to_reg_o  = ctrl_p1.memToReg;
    assign reg_dst_o     = ctrl_p1.regDst;
    assign alu_op_o      = ALUOP_W'(ctrl_p1.aluOp);
    assign rs_o          = rs_p1;
    assign rt_o          = rt_p1;
    assign wr_addr_o     = wrAddr_p1;
    assign illegal_o     = illegal_p1;
    assign bubbles_o     = bubbleCnt;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: decode table vectors on a LOAD_STALLS=1 instance,
// plus load-use, flush, reset-abort and saturation sequences on a
// LOAD_STALLS=3 / PERF_W=4 instance.
module tb_id_ctrl_stage;

    typedef struct packed {
        logic       vld;
        logic       br;
        logic       jmp;
        logic       mr;
        logic       mw;
        logic       asrc;
        logic       rw;
        logic [1:0] bt;
        logic [1:0] m2r;
        logic [1:0] rdst;
        logic [2:0] alu;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wr;
        logic       ill;
    } out_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic        stall;
        out_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: LOAD_STALLS=1
    logic        vA = 1'b0, fA = 1'b0;
    logic [31:0] iA = '0;
    logic        stallA, validA, branchA, jumpA, memReadA, memWriteA, aluSrcA, regWriteA, illegalA;
    logic [1:0]  branchTypeA, memToRegA, regDstA;
    logic [2:0]  aluOpA;
    logic [4:0]  rsA, rtA, wrAddrA;
    logic [15:0] bubblesA;

    // Instance B: LOAD_STALLS=3, PERF_W=4
    logic        vB = 1'b0, fB = 1'b0;
    logic [31:0] iB = '0;
    logic        stallB, validB, branchB, jumpB, memReadB, memWriteB, aluSrcB, regWriteB, illegalB;
    logic [1:0]  branchTypeB, memToRegB, regDstB;
    logic [2:0]  aluOpB;
    logic [4:0]  rsB, rtB, wrAddrB;
    logic [3:0]  bubblesB;

    out_t outA, outB;
    assign outA = {validA, branchA, jumpA, memReadA, memWriteA, aluSrcA, regWriteA,
                   branchTypeA, memToRegA, regDstA, aluOpA, rsA, rtA, wrAddrA, illegalA};
    assign outB = {validB, branchB, jumpB, memReadB, memWriteB, aluSrcB, regWriteB,
                   branchTypeB, memToRegB, regDstB, aluOpB, rsB, rtB, wrAddrB, illegalB};

    id_ctrl_stage #(.LOAD_STALLS(1), .ALUOP_W(3), .PERF_W(16)) uA (
        .clk_i(clk), .rst_i(rst), .valid_i(vA), .instr_i(iA), .flush_i(fA),
        .stall_o(stallA), .valid_o(validA), .branch_o(branchA), .jump_o(jumpA),
        .mem_read_o(memReadA), .mem_write_o(memWriteA), .alu_src_o(aluSrcA),
        .reg_write_o(regWriteA), .branch_type_o(branchTypeA), .mem_to_reg_o(memToRegA),
        .reg_dst_o(regDstA), .alu_op_o(aluOpA), .rs_o(rsA), .rt_o(rtA),
        .wr_addr_o(wrAddrA), .illegal_o(illegalA), .bubbles_o(bubblesA)
    );

    id_ctrl_stage #(.LOAD_STALLS(3), .ALUOP_W(3), .PERF_W(4)) uB (
        .clk_i(clk), .rst_i(rst), .valid_i(vB), .instr_i(iB), .flush_i(fB),
        .stall_o(stallB), .valid_o(validB), .branch_o(branchB), .jump_o(jumpB),
        .mem_read_o(memReadB), .mem_write_o(memWriteB), .alu_src_o(aluSrcB),
        .reg_write_o(regWriteB), .branch_type_o(branchTypeB), .mem_to_reg_o(memToRegB),
        .reg_dst_o(regDstB), .alu_op_o(aluOpB), .rs_o(rsB), .rt_o(rtB),
        .wr_addr_o(wrAddrB), .illegal_o(illegalB), .bubbles_o(bubblesB)
    );

    int nChecks = 0;
    int nFails  = 0;

    function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int rd);
        return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic out_t mkExp(input logic vld, input logic br, input logic jmp,
                                   input logic mr, input logic mw, input logic asrc,
                                   input logic rw, input logic [1:0] bt, input logic [1:0] m2r,
                                   input logic [1:0] rdst, input logic [2:0] alu,
                                   input int rs, input int rt, input int wr, input logic ill);
        return {vld, br, jmp, mr, mw, asrc, rw, bt, m2r, rdst, alu, 5'(rs), 5'(rt), 5'(wr), ill};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[16];
    out_t zero;

    initial begin
        int stalls;
        zero = '0;

        vecs[0]  = {1'b1, mk(0, 1, 2, 3),   1'b0, mkExp(1,0,0,0,0,0,1,2'b00,2'b00,2'b01,3'b000, 1, 2, 3, 0)};
        vecs[1]  = {1'b1, mk(2, 4, 5, 6),   1'b0, mkExp(1,0,1,0,0,0,0,2'b00,2'b00,2'b00,3'b111, 4, 5, 0, 0)};
        vecs[2]  = {1'b1, mk(3, 0, 0, 0),   1'b0, mkExp(1,0,1,0,0,0,1,2'b00,2'b11,2'b10,3'b111, 0, 0, 31, 0)};
        vecs[3]  = {1'b1, mk(4, 7, 9, 0),   1'b0, mkExp(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b001, 7, 9, 0, 0)};
        vecs[4]  = {1'b1, mk(5, 7, 9, 0),   1'b0, mkExp(1,1,0,0,0,0,0,2'b11,2'b00,2'b00,3'b010, 7, 9, 0, 0)};
        vecs[5]  = {1'b1, mk(6, 7, 9, 0),   1'b0, mkExp(1,1,0,0,0,0,0,2'b10,2'b00,2'b00,3'b001, 7, 9, 0, 0)};
        vecs[6]  = {1'b1, mk(7, 7, 9, 0),   1'b0, mkExp(1,1,0,0,0,0,0,2'b01,2'b00,2'b00,3'b001, 7, 9, 0, 0)};
        vecs[7]  = {1'b1, mk(8, 1, 12, 0),  1'b0, mkExp(1,0,0,0,0,1,1,2'b00,2'b00,2'b00,3'b011, 1, 12, 12, 0)};
        vecs[8]  = {1'b1, mk(13, 2, 13, 20),1'b0, mkExp(1,0,0,0,0,1,1,2'b00,2'b00,2'b00,3'b101, 2, 13, 13, 0)};
        vecs[9]  = {1'b1, mk(15, 0, 14, 0), 1'b0, mkExp(1,0,0,0,0,0,1,2'b00,2'b10,2'b00,3'b110, 0, 14, 14, 0)};
        vecs[10] = {1'b1, mk(35, 3, 15, 0), 1'b0, mkExp(1,0,0,1,0,1,1,2'b00,2'b01,2'b00,3'b011, 3, 15, 15, 0)};
        vecs[11] = {1'b1, mk(43, 4, 5, 7),  1'b0, mkExp(1,0,0,0,1,1,0,2'b00,2'b00,2'b01,3'b011, 4, 5, 0, 0)};
        vecs[12] = {1'b0, mk(0, 1, 2, 3),   1'b0, zero};
        vecs[13] = {1'b1, mk(63, 1, 2, 3),  1'b0, mkExp(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000, 0, 0, 0, 1)};
        vecs[14] = {1'b1, mk(1, 1, 2, 3),   1'b0, mkExp(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000, 0, 0, 0, 1)};
        vecs[15] = {1'b0, mk(63, 1, 2, 3),  1'b0, zero};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("resetA_outputs", outA, zero);
        chk("resetA_bubbles", bubblesA, 0);
        chk("resetA_stall", stallA, 0);
        chk("resetB_outputs", outB, zero);
        chk("resetB_bubbles", bubblesB, 0);
        rst = 1'b0;

        // Decode table
        for (int k = 0; k < 16; k++) begin
            vA = vecs[k].valid;
            iA = vecs[k].instr;
            #1;
            chk($sformatf("vec%0d_stall", k), stallA, vecs[k].stall);
            tick();
            chk($sformatf("vec%0d_out", k), outA, vecs[k].exp);
        end
        vA = 1'b0;
        chk("table_bubbles", bubblesA, 2);

        // Load-use with LOAD_STALLS=1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vA = 1'b1;
        iA = mk(35, 0, 8, 0);
        #1;
        chk("ls1_lw_stall", stallA, 0);
        tick();
        chk("ls1_lw_issue", {memReadA, wrAddrA}, {1'b1, 5'd8});
        iA = mk(0, 8, 10, 9);
        #1;
        chk("ls1_hazard_stall", stallA, 1);
        tick();
        chk("ls1_bubble_valid", validA, 0);
        chk("ls1_bubble_cnt", bubblesA, 1);
        chk("ls1_release_stall", stallA, 0);
        tick();
        chk("ls1_add_issue", {validA, rsA, rtA, wrAddrA}, {1'b1, 5'd8, 5'd10, 5'd9});
        chk("ls1_final_cnt", bubblesA, 1);

        // LW $0 then a use of $0: no hazard
        iA = mk(35, 0, 0, 0);
        tick();
        iA = mk(0, 0, 0, 5);
        #1;
        chk("lw0_no_stall", stallA, 0);
        tick();
        chk("lw0_use_issue", {validA, wrAddrA}, {1'b1, 5'd5});
        vA = 1'b0;

        // Load-use with LOAD_STALLS=3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vB = 1'b1;
        iB = mk(35, 0, 8, 0);
        tick();
        iB = mk(0, 8, 10, 9);
        #1;
        stalls = 0;
        for (int k = 0; k < 10 && stallB; k++) begin
            stalls++;
            tick();
            chk($sformatf("ls3_bubble%0d_valid", k), validB, 0);
        end
        chk("ls3_stall_cycles", stalls, 3);
        chk("ls3_bubbles", bubblesB, 3);
        tick();
        chk("ls3_add_issue", {validB, wrAddrB}, {1'b1, 5'd9});

        // Flush during first HOLD cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        iB = mk(35, 0, 8, 0);
        tick();
        iB = mk(0, 8, 10, 9);
        #1;
        chk("flush_pre_stall", stallB, 1);
        tick();
        fB = 1'b1;
        #1;
        chk("flush_hold_stall", stallB, 0);
        tick();
        fB = 1'b0;
        chk("flush_bubble", outB, zero);
        chk("flush_bubbles", bubblesB, 2);
        #1;
        chk("flush_back_in_run", stallB, 0);
        tick();
        chk("flush_add_issue", {validB, wrAddrB}, {1'b1, 5'd9});

        // Reset in the middle of a stall
        iB = mk(35, 0, 8, 0);
        tick();
        iB = mk(0, 8, 10, 9);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_outputs", outB, zero);
        #1;
        chk("rstmid_stall", stallB, 0);

        // Illegal opcode pulse
        iB = mk(63, 1, 2, 3);
        tick();
        vB = 1'b0;
        chk("illegal_pulse", outB, mkExp(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000, 0, 0, 0, 1));
        chk("illegal_bubbles", bubblesB, 1);
        tick();
        chk("illegal_clear", illegalB, 0);

        // Saturation at PERF_W=4
        vB = 1'b1;
        for (int k = 0; k < 14; k++) tick();
        chk("sat_reach_f", bubblesB, 4'hF);
        for (int k = 0; k < 6; k++) tick();
        chk("sat_hold_f", bubblesB, 4'hF);
        vB = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered instruction-decode control stage for the pipelined MIPS core, sitting between the IF/ID and ID/EX pipeline registers. It decodes the opcode into the full control bundle, resolves the write-back register address, and launches the bundle into EX one cycle later. It detects load-use hazards against its own previously issued load and stalls for a parametrised number of cycles, inserting bubbles. It squashes on branch/jump flush, flags illegal opcodes, and counts bubbles.

## Interface
- `LOAD_STALLS`, 1: stall cycles per load-use hazard; legal range 1..3.
- `ALUOP_W`, 3: width of the ALU op code.
- `PERF_W`, 16: width of the bubble counter.
---
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `valid_i` in 1: IF/ID holds a real instruction.
- `instr_i` in 32: IF/ID instruction. op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11].
- `flush_i` in 1: taken branch/jump resolved; squash the ID instruction.
- `stall_o` out 1: hold PC and IF/ID. Combinational.
- `valid_o` out 1: the EX-stage bundle is a real instruction.
- `branch_o`, `jump_o`, `mem_read_o`, `mem_write_o`, `alu_src_o`, `reg_write_o` out 1 each: registered controls.
- `branch_type_o` out 2: registered branch type.
- `mem_to_reg_o` out 2: registered write-back source select.
- `reg_dst_o` out 2: registered destination select.
- `alu_op_o` out ALUOP_W: registered ALU op.
- `rs_o`, `rt_o`, `wr_addr_o` out 5 each: registered register addresses; `wr_addr_o` is the resolved destination.
- `illegal_o` out 1: registered one-cycle pulse for an unknown opcode.
- `bubbles_o` out PERF_W: saturating count of bubbles inserted.

## Operation
- Decode table, opcode → alu_op / alu_src / reg_write / reg_dst / mem_to_reg / branch,branch_type / jump / mem_read,mem_write:
  - 0 R-type: 000/0/1/01/00/0,00/0/0,0
  - 2 J: 111/0/0/00/00/0,00/1/0,0
  - 3 JAL: 111/0/1/10/11/0,00/1/0,0
  - 4 BEQ: 001/0/0/00/00/1,00/0/0,0
  - 5 BNE: 010/0/0/00/00/1,11/0/0,0
  - 6 BLT: 001/0/0/00/00/1,10/0/0,0
  - 7 BLE: 001/0/0/00/00/1,01/0/0,0
  - 8 ADDI: 011/1/1/00/00/0,00/0/0,0
  - 13 ORI: 101/1/1/00/00/0,00/0/0,0
  - 15 LI: 110/0/1/00/10/0,00/0/0,0
  - 35 LW: 011/1/1/00/01/0,00/0/1,0
  - 43 SW: 011/1/0/01/00/0,00/0/0,1
- Any other opcode decodes to the bubble bundle. If valid_i is set, `illegal_o` pulses on the next cycle.
- `wr_addr_o` is resolved from reg_dst: 00→rt, 01→rd, 10→31. It is forced to 0 whenever reg_write is 0.
- Bubble bundle: every control output 0, `valid_o` 0, `wr_addr_o`, `rs_o`, `rt_o` all 0.
- Hazard condition: `valid_i` && `valid_o` && `mem_read_o` && `wr_addr_o`≠0 && (`wr_addr_o`==rs || `wr_addr_o`==rt).
- FSM states:
  - RUN: on hazard, assert `stall_o` and issue a bubble. Go to HOLD with cnt=LOAD_STALLS-1, or stay in RUN if LOAD_STALLS=1. Otherwise issue the decoded bundle, or a bubble if valid_i=0.
  - HOLD: assert `stall_o` and issue a bubble. Decrement cnt; when cnt reaches 0, return to RUN, and the held instruction issues on the next cycle.
- `flush_i` has priority over everything:
  - issue a bubble, deassert `stall_o`, force RUN, clear cnt.
  - `illegal_o` is suppressed.
- `bubbles_o` increments on every cycle that issues a bubble while valid_i=1 (stall, flush, or illegal). It saturates at all-ones.

## Timing
- Reset: all outputs 0, FSM in RUN, cnt 0, `bubbles_o` 0.
- Asserting `rst_i` mid-stall aborts the stall on the next edge.
- Decode latency is one cycle: the instruction at edge n appears on the outputs after edge n+1.
- A load-use pair loses exactly LOAD_STALLS cycles.
- `stall_o` is combinational from FSM state, hazard condition and `flush_i`. It has no dependency on the outputs of the same cycle.
- If flush_i and a hazard occur in the same cycle, the flush wins and no stall is taken.

## Structure
- Package `ctrl_pkg` holds:
  - opcode localparams;
  - ALU op codes;
  - reg_dst / mem_to_reg / branch_type encodings;
  - the control-bundle struct and its bubble constant.
- Sub-module `main_ctrl_dec`: the purely combinational opcode→bundle table with an illegal flag. The pipeline registers, FSM, hazard compare and counter live in `id_ctrl_stage`.

## Test plan
- Reset, then LW $8 (op 35, rt=8) followed by ADD $9,$8,$10:
  - with LOAD_STALLS=1: `stall_o`=1 for exactly 1 cycle, one bubble issued, ADD issues next, `bubbles_o`=1;
  - with LOAD_STALLS=3: 3 stall cycles and `bubbles_o`=3.
- LW $0 followed by an instruction using $0 → no stall.
- JAL → one cycle later `jump_o`=1, `reg_write_o`=1, `mem_to_reg_o`=11, `wr_addr_o`=31.
- `flush_i`=1 during the first HOLD cycle of a LOAD_STALLS=3 stall → `stall_o`=0 immediately, bubble issued, FSM back in RUN.
- Opcode 63 with valid_i=1 → `illegal_o` pulses for 1 cycle, `valid_o`=0, `bubbles_o` increments.
- Force `bubbles_o` to all-ones (PERF_W=4, 16 bubbles) → it stays at 4'hF.
